ava_vram_writer: RTL and testbench
==================================

Name: ava_vram_writer

Overview:
- Write-side VRAM engine for the direct-mode framebuffer.
- Accepts drawing commands (single pixel or clipped rectangle fill) over a valid/ready handshake and writes 6-bit palette indices into VRAM on the BRAM write port. Each VRAM word holds one pixel, and the index sits in bits [5:0].
- The display path reads the same VRAM on the other BRAM port, so this block needs no arbitration.

Parameters:
- WIDTH, 320, framebuffer width in pixels.
- HEIGHT, 200, framebuffer height in pixels.
- ADDR_W, 17, VRAM word address width. WIDTH*HEIGHT must be at most 2**ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_op  in  ava_wr_op_t (1)  OP_PIXEL=0, OP_FILL=1
- cmd_p0  in  coords_t  pixel position, or fill top-left corner (inclusive)
- cmd_p1  in  coords_t  fill bottom-right corner (inclusive); ignored for OP_PIXEL
- cmd_color  in  6  palette index to write
- vram_we  out  1  VRAM write strobe
- vram_wa  out  ADDR_W  VRAM write address
- vram_wd  out  32  VRAM write data: {26'b0, color}
- busy  out  1  high in WRITE or FIN
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (asynchronous) forces:
  - state to IDLE
  - vram_we, busy and done to 0
  - vram_wa and vram_wd to 0
  - cmd_ready to 1 after reset deasserts
- States: IDLE, WRITE, FIN.
- Accept: a command is accepted when cmd_valid && cmd_ready on a rising edge. At that edge the block latches op, p0, p1 and color. Inputs are ignored outside acceptance.
- Clipping, done at acceptance:
  - Fill: x_end = min(p1.x, WIDTH-1) and y_end = min(p1.y, HEIGHT-1).
  - Pixel: x_end = p0.x and y_end = p0.y.
  - The command is empty if p0.x > x_end, p0.y > y_end, p0.x >= WIDTH, or p0.y >= HEIGHT.
- IDLE -> WRITE on acceptance of a non-empty command. IDLE -> FIN on acceptance of an empty command.
- WRITE: one VRAM write per cycle, in row-major order from (p0.x, p0.y) to (x_end, y_end).
  - vram_we=1.
  - vram_wa = row_base + x, where row_base is initialised to p0.y*WIDTH at acceptance. The single multiply happens only at acceptance.
  - Within a row, x increments by 1 each cycle.
  - At the row end, x returns to p0.x and row_base increases by WIDTH (add only, no multiply).
  - After the write at (x_end, y_end), the state goes to FIN.
- FIN: done=1 for exactly one cycle and vram_we=0, then IDLE.
- Cycle timing:
  - A pixel command accepted at edge 0 is written during cycle 1, done is high in cycle 2, and cmd_ready is high in cycle 3.
  - A fill of N pixels makes writes in cycles 1..N and pulses done in cycle N+1.
- Outputs are registered, with no combinational path from cmd_* to vram_*.
- vram_wa/vram_wd hold their last values when vram_we=0.
- cmd_ready=0 while busy. A held cmd_valid is accepted on the first IDLE edge.
- Reset mid-command: vram_we drops immediately (asynchronous), the command is abandoned, and done does not pulse.
- Address arithmetic is unsigned at ADDR_W bits. With legal parameters, clipping guarantees no overflow.

Decomposition:
- ava_pkg gains:
  - typedef enum logic [0:0] ava_wr_op_t {OP_PIXEL, OP_FILL}
  - constants AVA_FB_WIDTH=320 and AVA_FB_HEIGHT=200
- coords_t (x, y unsigned) is reused from ava_pkg unchanged.
- One sub-module: ava_fill_scanner. It holds the row/column counters plus the incremental row_base/address, and provides a last-pixel flag. The top level keeps the FSM, handshake, clipping and output registers.

Test Plan:
- OP_PIXEL p0=(5,2), color=0x2A:
  - exactly one write, vram_wa=645, vram_wd=0x0000002A, in cycle 1
  - done in cycle 2
  - cmd_ready back high in cycle 3
- OP_FILL p0=(318,0), p1=(400,1), color=0x01: clipped to x 318..319, writes at 318, 319, 638, 639 on consecutive cycles, done in cycle 5.
- Empty OP_FILL p0=(10,5), p1=(9,5): no vram_we, done in cycle 1.
- OP_PIXEL p0=(320,0), which is off-screen: no write, done in cycle 1.
- cmd_valid held high with two queued commands:
  - the second is accepted only once the first has returned to IDLE
  - the second's first write appears 1 cycle after its acceptance
- Reset asserted during write 3 of a 10-pixel fill:
  - vram_we is 0 in the same cycle
  - no done pulse
  - a new pixel command after reset release completes normally

Source files
------------

// File: rtl/ava_pkg.sv
// rtl/ava_pkg.sv - shared types and framebuffer constants for the ava video block
package ava_pkg;

  localparam int AVA_COORD_W   = 10;
  localparam int AVA_FB_WIDTH  = 320;
  localparam int AVA_FB_HEIGHT = 200;

  typedef struct packed {
    logic [AVA_COORD_W-1:0] x;
    logic [AVA_COORD_W-1:0] y;
  } coords_t;

  typedef enum logic [0:0] {
    OP_PIXEL = 1'b0,
    OP_FILL  = 1'b1
  } ava_wr_op_t;

endpackage

// File: rtl/ava_fill_scanner.sv
// rtl/ava_fill_scanner.sv - row-major rectangle walker with incremental VRAM address
module ava_fill_scanner
  import ava_pkg::*;
#(
  parameter int WIDTH  = AVA_FB_WIDTH,
  parameter int ADDR_W = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   advance_i,
  input  logic [AVA_COORD_W-1:0] x0_i,
  input  logic [AVA_COORD_W-1:0] y0_i,
  input  logic [AVA_COORD_W-1:0] x_end_i,
  input  logic [AVA_COORD_W-1:0] y_end_i,
  input  logic [ADDR_W-1:0]      row_base_i,
  output logic                   last_o,
  output logic [ADDR_W-1:0]      next_addr_o
);

  logic [AVA_COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [AVA_COORD_W-1:0] x0_q, x0_d, x_end_q, x_end_d, y_end_q, y_end_d;
  logic [ADDR_W-1:0]      row_base_q, row_base_d;
  logic                   row_end;

  assign row_end = (x_q == x_end_q);
  assign last_o  = row_end && (y_q == y_end_q);

  // Address of the pixel after the current one; row wrap adds WIDTH, never multiplies
  always_comb begin
    if (row_end) begin
      next_addr_o = row_base_q + ADDR_W'(WIDTH) + ADDR_W'(x0_q);
    end else begin
      next_addr_o = row_base_q + ADDR_W'(x_q) + ADDR_W'(1);
    end
  end

  // Counter updates: load captures the clipped rectangle, advance steps one pixel
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    x0_d       = x0_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    if (load_i) begin
      x_d        = x0_i;
      y_d        = y0_i;
      x0_d       = x0_i;
      x_end_d    = x_end_i;
      y_end_d    = y_end_i;
      row_base_d = row_base_i;
    end else if (advance_i) begin
      if (row_end) begin
        x_d        = x0_q;
        y_d        = y_q + AVA_COORD_W'(1);
        row_base_d = row_base_q + ADDR_W'(WIDTH);
      end else begin
        x_d = x_q + AVA_COORD_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      x0_q       <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      x0_q       <= x0_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/ava_vram_writer.sv
// rtl/ava_vram_writer.sv - command-driven pixel/rectangle writer for the VRAM write port
module ava_vram_writer
  import ava_pkg::*;
#(
  parameter int WIDTH  = AVA_FB_WIDTH,
  parameter int HEIGHT = AVA_FB_HEIGHT,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  ava_wr_op_t        cmd_op,
  input  coords_t           cmd_p0,
  input  coords_t           cmd_p1,
  input  logic [5:0]        cmd_color,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_wa,
  output logic [31:0]       vram_wd,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  localparam logic [31:0]            WIDTH_U  = 32'(WIDTH);
  localparam logic [31:0]            HEIGHT_U = 32'(HEIGHT);
  localparam logic [AVA_COORD_W-1:0] X_MAX    = AVA_COORD_W'(WIDTH - 1);
  localparam logic [AVA_COORD_W-1:0] Y_MAX    = AVA_COORD_W'(HEIGHT - 1);

  logic [1:0]             state_q, state_d;
  logic [ADDR_W-1:0]      wa_q, wa_d;
  logic [31:0]            wd_q, wd_d;
  logic                   accept, empty;
  logic [AVA_COORD_W-1:0] x_end, y_end;
  logic [ADDR_W-1:0]      row_base0;
  logic                   scan_load, scan_adv, scan_last;
  logic [ADDR_W-1:0]      scan_next;

  assign accept    = cmd_valid && cmd_ready;
  assign scan_load = accept && !empty;
  assign scan_adv  = (state_q == ST_WRITE) && !scan_last;

  // Clip the offered command to the framebuffer and find its first row base
  always_comb begin
    x_end = cmd_p0.x;
    y_end = cmd_p0.y;
    if (cmd_op == OP_FILL) begin
      x_end = (cmd_p1.x > X_MAX) ? X_MAX : cmd_p1.x;
      y_end = (cmd_p1.y > Y_MAX) ? Y_MAX : cmd_p1.y;
    end
    empty = (cmd_p0.x > x_end) || (cmd_p0.y > y_end) ||
            (32'(cmd_p0.x) >= WIDTH_U) || (32'(cmd_p0.y) >= HEIGHT_U);
    row_base0 = ADDR_W'(cmd_p0.y) * ADDR_W'(WIDTH);
  end

  ava_fill_scanner #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_scanner (
    .clk        (clk),
    .reset      (reset),
    .load_i     (scan_load),
    .advance_i  (scan_adv),
    .x0_i       (cmd_p0.x),
    .y0_i       (cmd_p0.y),
    .x_end_i    (x_end),
    .y_end_i    (y_end),
    .row_base_i (row_base0),
    .last_o     (scan_last),
    .next_addr_o(scan_next)
  );

  // FSM sequencing; write address/data only change when a write is being issued
  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (empty) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_WRITE;
            wa_d    = row_base0 + ADDR_W'(cmd_p0.x);
            wd_d    = {26'b0, cmd_color};
          end
        end
      end
      ST_WRITE: begin
        if (scan_last) begin
          state_d = ST_FIN;
        end else begin
          wa_d = scan_next;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and write-port registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign vram_we   = (state_q == ST_WRITE);
  assign busy      = (state_q == ST_WRITE) || (state_q == ST_FIN);
  assign done      = (state_q == ST_FIN);
  assign vram_wa   = wa_q;
  assign vram_wd   = wd_q;

endmodule

// File: tb/tb_ava_vram_writer.sv
// tb/tb_ava_vram_writer.sv - self-checking bench for ava_vram_writer
module tb_ava_vram_writer;
  import ava_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  ava_wr_op_t  cmd_op = OP_PIXEL;
  coords_t     cmd_p0 = '0;
  coords_t     cmd_p1 = '0;
  logic [5:0]  cmd_color = '0;
  logic        vram_we;
  logic [16:0] vram_wa;
  logic [31:0] vram_wd;
  logic        busy;
  logic        done;

  ava_vram_writer #(.WIDTH(320), .HEIGHT(200), .ADDR_W(17)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_p0   (cmd_p0),
    .cmd_p1   (cmd_p1),
    .cmd_color(cmd_color),
    .vram_we  (vram_we),
    .vram_wa  (vram_wa),
    .vram_wd  (vram_wd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: each accepted command becomes a list of per-cycle expectations
  // kind 0 = idle, 1 = write, 2 = done cycle
  typedef struct {
    int          kind;
    logic [16:0] wa;
    logic [31:0] wd;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        e;
  int          cur_kind = 0;
  logic [16:0] exp_wa = '0;
  logic [31:0] exp_wd = '0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_edge = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      cur_kind = 0;
      exp_wa   = '0;
      exp_wd   = '0;
    end else begin
      cyc++;
      if (cur_kind == 0 && cmd_valid) begin
        int x0, y0, x1, y1;
        acc_cnt++;
        acc_edge = cyc;
        x0 = int'(cmd_p0.x);
        y0 = int'(cmd_p0.y);
        if (cmd_op == OP_FILL) begin
          x1 = (int'(cmd_p1.x) > 319) ? 319 : int'(cmd_p1.x);
          y1 = (int'(cmd_p1.y) > 199) ? 199 : int'(cmd_p1.y);
        end else begin
          x1 = x0;
          y1 = y0;
        end
        for (int y = y0; y <= y1; y++) begin
          for (int x = x0; x <= x1; x++) begin
            if (x < 320 && y < 200) begin
              exp_q.push_back('{kind: 1, wa: 17'(y * 320 + x), wd: {26'b0, cmd_color}});
            end
          end
        end
        exp_q.push_back('{kind: 2, wa: '0, wd: '0});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cur_kind = e.kind;
        if (e.kind == 1) begin
          exp_wa = e.wa;
          exp_wd = e.wd;
        end
      end else begin
        cur_kind = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_we", 32'(vram_we), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
    end else begin
      chk("we", 32'(vram_we), 32'(cur_kind == 1));
      chk("done", 32'(done), 32'(cur_kind == 2));
      chk("busy", 32'(busy), 32'(cur_kind != 0));
      chk("ready", 32'(cmd_ready), 32'(cur_kind == 0));
      chk("wa", 32'(vram_wa), 32'(exp_wa));
      chk("wd", vram_wd, exp_wd);
    end
  end

  task automatic wait_acc(input int start);
    int n;
    n = 0;
    while (acc_cnt == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt == start) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no acceptance expected one within 100 cycles");
    end
  endtask

  task automatic set_cmd(input ava_wr_op_t op, input int ax, input int ay,
                         input int bx, input int by, input logic [5:0] col);
    cmd_op    = op;
    cmd_p0.x  = AVA_COORD_W'(ax);
    cmd_p0.y  = AVA_COORD_W'(ay);
    cmd_p1.x  = AVA_COORD_W'(bx);
    cmd_p1.y  = AVA_COORD_W'(by);
    cmd_color = col;
  endtask

  // Offer a command, return at the negedge of the first cycle after acceptance
  task automatic send(input ava_wr_op_t op, input int ax, input int ay,
                      input int bx, input int by, input logic [5:0] col);
    int start;
    set_cmd(op, ax, ay, bx, by, col);
    start     = acc_cnt;
    cmd_valid = 1'b1;
    wait_acc(start);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cur_kind != 0 || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    int a_edge;
    int start;
    logic [16:0] fill_wa[4];
    fill_wa = '{17'd318, 17'd319, 17'd638, 17'd639};

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("init_ready", 32'(cmd_ready), 32'(1));
    chk("init_busy", 32'(busy), 32'(0));
    chk("init_we", 32'(vram_we), 32'(0));
    chk("init_wa", 32'(vram_wa), 32'(0));
    chk("init_wd", vram_wd, 32'(0));

    // Single pixel (5,2)
    send(OP_PIXEL, 5, 2, 0, 0, 6'h2A);
    chk("px_we", 32'(vram_we), 32'(1));
    chk("px_wa", 32'(vram_wa), 32'd645);
    chk("px_wd", vram_wd, 32'h0000002A);
    @(negedge clk);
    chk("px_done", 32'(done), 32'(1));
    chk("px_we_off", 32'(vram_we), 32'(0));
    @(negedge clk);
    chk("px_ready", 32'(cmd_ready), 32'(1));
    wait_idle();

    // Clipped fill at the right edge
    send(OP_FILL, 318, 0, 400, 1, 6'h01);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("fill_we", 32'(vram_we), 32'(1));
      chk("fill_wa", 32'(vram_wa), 32'(fill_wa[i]));
    end
    @(negedge clk);
    chk("fill_done", 32'(done), 32'(1));
    wait_idle();

    // Empty fill: done right away, address held
    send(OP_FILL, 10, 5, 9, 5, 6'h07);
    chk("empty_done", 32'(done), 32'(1));
    chk("empty_we", 32'(vram_we), 32'(0));
    chk("empty_wa_hold", 32'(vram_wa), 32'd639);
    wait_idle();

    // Off-screen pixel
    send(OP_PIXEL, 320, 0, 0, 0, 6'h3F);
    chk("off_done", 32'(done), 32'(1));
    chk("off_we", 32'(vram_we), 32'(0));
    wait_idle();

    // Two queued commands with cmd_valid held
    send(OP_PIXEL, 1, 1, 0, 0, 6'h03);
    a_edge = acc_edge;
    set_cmd(OP_PIXEL, 2, 0, 0, 0, 6'h04);
    start     = acc_cnt;
    cmd_valid = 1'b1;
    wait_acc(start);
    cmd_valid = 1'b0;
    chk("queue_gap", 32'(acc_edge - a_edge), 32'd3);
    chk("queue_we", 32'(vram_we), 32'(1));
    chk("queue_wa", 32'(vram_wa), 32'd2);
    chk("queue_wd", vram_wd, 32'h00000004);
    wait_idle();

    // Reset during write 3 of a 10-pixel fill
    send(OP_FILL, 0, 10, 9, 10, 6'h09);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", 32'(vram_we), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'(0));
    end
    send(OP_PIXEL, 7, 3, 0, 0, 6'h05);
    chk("post_we", 32'(vram_we), 32'(1));
    chk("post_wa", 32'(vram_wa), 32'd967);
    @(negedge clk);
    chk("post_done", 32'(done), 32'(1));
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
